// File: rtl/multicycle_control_pkg.sv
// Shared opcode, ALU-op and FSM encodings for the multi-cycle RISC-V sequencer.
// The pipelined core reuses the opcode and ALU-op constants.
package multicycle_control_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [6:0] F7_MUL   = 7'b0000001;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_RTYPE = 2'b10;
   localparam logic [1:0] ALU_ITYPE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_MUL_WAIT,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_R,
      C_I,
      C_LW,
      C_SW,
      C_BEQ,
      C_NONE
   } iclass_t;

endpackage

// File: rtl/multicycle_decode.sv
// Combinational opcode classifier: maps the IR opcode field to an
// instruction class and flags opcodes the sequencer does not support.
module multicycle_decode
   import multicycle_control_pkg::*;
(
   input  logic [6:0] i_op,
   output logic [2:0] o_class,
   output logic       o_legal
);

   always_comb begin
      o_class = C_NONE;
      o_legal = 1'b1;
      case (i_op)
         OP_RTYPE: o_class = C_R;
         OP_ITYPE: o_class = C_I;
         OP_LW:    o_class = C_LW;
         OP_SW:    o_class = C_SW;
         OP_BEQ:   o_class = C_BEQ;
         default:  o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer driving the shared PC/IR/ALU/regfile datapath.
// Define MULTICYCLE_MUL_EN to route funct7=0000001 R-types through the multiplier.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [6:0]       Op_i,
   input  logic [6:0]       Funct7_i,
   input  logic             Zero_i,
   input  logic             IMemReady_i,
   input  logic             DMemReady_i,
   input  logic             MulDone_i,
   output logic             PCWrite_o,
   output logic             PCSrc_o,
   output logic             IRWrite_o,
   output logic             IMemReq_o,
   output logic             DMemReq_o,
   output logic             DMemWrite_o,
   output logic [1:0]       ALUOp_o,
   output logic             ALUSrc_o,
   output logic             RegWrite_o,
   output logic             MemtoReg_o,
   output logic             MulStart_o,
   output logic             Illegal_o,
   output logic             BusErr_o,
   output logic             Halted_o,
   output logic [CNT_W-1:0] RetireCnt_o
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t             r_state;
   iclass_t            r_class;
   logic               r_isMul;
   logic [WAIT_W-1:0]  r_waitCnt;
   logic [CNT_W-1:0]   r_retireCnt;

   logic [2:0]         w_decClass;
   logic               w_legal;
   logic               w_isMul;
   logic               w_mulDone;
   logic               w_ready;
   logic               w_timeout;
   logic               w_retire;

   multicycle_decode u_decode (
      .i_op    (Op_i),
      .o_class (w_decClass),
      .o_legal (w_legal)
   );

`ifdef MULTICYCLE_MUL_EN
   assign w_isMul   = (Funct7_i == F7_MUL);
   assign w_mulDone = MulDone_i;
`else
   logic w_unused;
   assign w_isMul   = 1'b0;
   assign w_mulDone = 1'b0;
   assign w_unused  = ^{Funct7_i, MulDone_i};
`endif

   // Ready that belongs to whichever bus is currently being requested.
   assign w_ready   = (r_state == S_FETCH) ? IMemReady_i : DMemReady_i;
   assign w_timeout = (MEM_TIMEOUT != 0) && !w_ready &&
                      (r_waitCnt == WAIT_W'(MEM_TIMEOUT - 1));
   assign w_retire  = !rst_i &&
                      ((r_state == S_EXEC && r_class == C_BEQ) ||
                       (r_state == S_MEM && r_class == C_SW && DMemReady_i) ||
                       (r_state == S_WB));
   assign RetireCnt_o = r_retireCnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_class     <= C_NONE;
         r_isMul     <= 1'b0;
         r_waitCnt   <= '0;
         r_retireCnt <= '0;
      end else begin
         r_waitCnt <= '0;
         if (w_retire)
            r_retireCnt <= r_retireCnt + CNT_W'(1);
         case (r_state)
            S_IDLE:   r_state <= S_FETCH;
            S_FETCH: begin
               if (IMemReady_i)
                  r_state <= S_DECODE;
               else if (w_timeout)
                  r_state <= S_HALT;
               else
                  r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end
            S_DECODE: begin
               if (w_legal) begin
                  r_class <= iclass_t'(w_decClass);
                  r_isMul <= (iclass_t'(w_decClass) == C_R) && w_isMul;
                  r_state <= S_EXEC;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_EXEC: begin
               case (r_class)
                  C_R:        r_state <= r_isMul ? S_MUL_WAIT : S_WB;
                  C_I:        r_state <= S_WB;
                  C_LW, C_SW: r_state <= S_MEM;
                  default:    r_state <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (DMemReady_i)
                  r_state <= (r_class == C_LW) ? S_WB : S_FETCH;
               else if (w_timeout)
                  r_state <= S_HALT;
               else
                  r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end
            S_WB:       r_state <= S_FETCH;
            S_MUL_WAIT: if (w_mulDone) r_state <= S_WB;
            S_HALT:     r_state <= S_HALT;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs are held low while reset is asserted so an aborted instruction writes nothing.
   always_comb begin
      PCWrite_o   = 1'b0;
      PCSrc_o     = 1'b0;
      IRWrite_o   = 1'b0;
      IMemReq_o   = 1'b0;
      DMemReq_o   = 1'b0;
      DMemWrite_o = 1'b0;
      ALUOp_o     = ALU_ADD;
      ALUSrc_o    = 1'b0;
      RegWrite_o  = 1'b0;
      MemtoReg_o  = 1'b0;
      MulStart_o  = 1'b0;
      Illegal_o   = 1'b0;
      BusErr_o    = 1'b0;
      Halted_o    = 1'b0;
      if (!rst_i) begin
         case (r_state)
            S_FETCH: begin
               IMemReq_o = 1'b1;
               IRWrite_o = IMemReady_i;
               PCWrite_o = IMemReady_i;
               BusErr_o  = w_timeout;
            end
            S_DECODE: Illegal_o = !w_legal;
            S_EXEC: begin
               case (r_class)
                  C_R: begin
                     ALUOp_o    = ALU_RTYPE;
                     MulStart_o = r_isMul;
                  end
                  C_I: begin
                     ALUOp_o  = ALU_ITYPE;
                     ALUSrc_o = 1'b1;
                  end
                  C_LW, C_SW: begin
                     ALUOp_o  = ALU_ADD;
                     ALUSrc_o = 1'b1;
                  end
                  C_BEQ: begin
                     ALUOp_o   = ALU_SUB;
                     PCWrite_o = Zero_i;
                     PCSrc_o   = Zero_i;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               DMemReq_o   = 1'b1;
               DMemWrite_o = (r_class == C_SW);
               BusErr_o    = w_timeout;
            end
            S_WB: begin
               RegWrite_o = 1'b1;
               MemtoReg_o = (r_class == C_LW);
            end
            S_HALT:  Halted_o = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: builds a per-cycle plan of inputs and
// expected outputs from instruction-level timing rules, then replays it on the DUT.
module tb_multicycle_control;

   localparam int TO = 4;
   localparam int CW = 4;

   localparam logic [6:0] R_OP   = 7'b0110011;
   localparam logic [6:0] I_OP   = 7'b0010011;
   localparam logic [6:0] LW_OP  = 7'b0000011;
   localparam logic [6:0] SW_OP  = 7'b0100011;
   localparam logic [6:0] BEQ_OP = 7'b1100011;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [6:0]    Op_i, Funct7_i;
   logic          Zero_i, IMemReady_i, DMemReady_i, MulDone_i;
   logic          PCWrite_o, PCSrc_o, IRWrite_o, IMemReq_o, DMemReq_o, DMemWrite_o;
   logic [1:0]    ALUOp_o;
   logic          ALUSrc_o, RegWrite_o, MemtoReg_o, MulStart_o, Illegal_o, BusErr_o, Halted_o;
   logic [CW-1:0] RetireCnt_o;

   always #5 clk_i = ~clk_i;

   multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .Funct7_i(Funct7_i), .Zero_i(Zero_i),
      .IMemReady_i(IMemReady_i), .DMemReady_i(DMemReady_i), .MulDone_i(MulDone_i),
      .PCWrite_o(PCWrite_o), .PCSrc_o(PCSrc_o), .IRWrite_o(IRWrite_o), .IMemReq_o(IMemReq_o),
      .DMemReq_o(DMemReq_o), .DMemWrite_o(DMemWrite_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
      .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MulStart_o(MulStart_o),
      .Illegal_o(Illegal_o), .BusErr_o(BusErr_o), .Halted_o(Halted_o), .RetireCnt_o(RetireCnt_o)
   );

   typedef struct {
      logic          rst;
      logic [6:0]    op;
      logic [6:0]    f7;
      logic          zero, iRdy, dRdy, mDone;
      logic [14:0]   expOut;
      logic [CW-1:0] expCnt;
   } cycle_t;

   cycle_t     plan[$];
   int         compared = 0;
   int         mismatched = 0;
   int         modelCnt = 0;
   logic [6:0] curOp = 7'd0;
   logic [6:0] curF7 = 7'd0;

   // Expected output vector order: PCWrite PCSrc IRWrite IMemReq DMemReq DMemWrite ALUOp ALUSrc RegWrite MemtoReg MulStart Illegal BusErr Halted
   function automatic logic [14:0] outv(input bit pcw, input bit pcs, input bit irw, input bit ireq,
                                        input bit dreq, input bit dwr, input bit [1:0] aop,
                                        input bit asrc, input bit regw, input bit m2r, input bit mst,
                                        input bit ill, input bit berr, input bit halt);
      return {pcw, pcs, irw, ireq, dreq, dwr, aop, asrc, regw, m2r, mst, ill, berr, halt};
   endfunction

   function automatic bit rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic addCycle(input bit rst, input bit iRdy, input bit dRdy, input bit mDone,
                           input bit zero, input logic [14:0] e);
      cycle_t c;
      c.rst = rst; c.op = curOp; c.f7 = curF7;
      c.iRdy = iRdy; c.dRdy = dRdy; c.mDone = mDone; c.zero = zero;
      c.expOut = e;
      c.expCnt = modelCnt[CW-1:0];
      plan.push_back(c);
   endtask

   task automatic retire();
      modelCnt = (modelCnt + 1) % (1 << CW);
   endtask

   task automatic addReset();
      addCycle(1, rnd(), rnd(), rnd(), rnd(), '0);
      modelCnt = 0;
      addCycle(1, rnd(), rnd(), rnd(), rnd(), '0);
      addCycle(0, rnd(), rnd(), rnd(), rnd(), '0);
   endtask

   task automatic addHalt();
      for (int k = 0; k < 3; k++)
         addCycle(0, rnd(), rnd(), rnd(), rnd(), outv(0,0,0,0,0,0,2'b00,0,0,0,0,0,0,1));
      addReset();
   endtask

   // A request phase: 'waits' not-ready cycles, then a ready cycle, unless the timeout fires first.
   task automatic addMemPhase(input bit isFetch, input int waits, output bit ok);
      bit dwr;
      dwr = (curOp == SW_OP);
      ok = 1'b1;
      for (int k = 0; k < waits; k++) begin
         if (k == TO - 1) begin
            if (isFetch) addCycle(0, 0, rnd(), rnd(), rnd(), outv(0,0,0,1,0,0,2'b00,0,0,0,0,0,1,0));
            else         addCycle(0, rnd(), 0, rnd(), rnd(), outv(0,0,0,0,1,dwr,2'b00,0,0,0,0,0,1,0));
            ok = 1'b0;
            return;
         end
         if (isFetch) addCycle(0, 0, rnd(), rnd(), rnd(), outv(0,0,0,1,0,0,2'b00,0,0,0,0,0,0,0));
         else         addCycle(0, rnd(), 0, rnd(), rnd(), outv(0,0,0,0,1,dwr,2'b00,0,0,0,0,0,0,0));
      end
      if (isFetch) addCycle(0, 1, rnd(), rnd(), rnd(), outv(1,0,1,1,0,0,2'b00,0,0,0,0,0,0,0));
      else         addCycle(0, rnd(), 1, rnd(), rnd(), outv(0,0,0,0,1,dwr,2'b00,0,0,0,0,0,0,0));
   endtask

   task automatic addWb(input bit lw, input bit abortWb);
      if (abortWb) begin
         addReset();
      end else begin
         addCycle(0, rnd(), rnd(), rnd(), rnd(), outv(0,0,0,0,0,0,2'b00,0,1,lw,0,0,0,0));
         retire();
      end
   endtask

   task automatic addInstr(input logic [6:0] op, input logic [6:0] f7, input int iWait,
                           input int dWait, input bit zero, input int mWait, input bit abortWb);
      bit ok;
      bit isMul;
      curOp = op;
      curF7 = f7;
      addMemPhase(1, iWait, ok);
      if (!ok) begin addHalt(); return; end
      if (!(op inside {R_OP, I_OP, LW_OP, SW_OP, BEQ_OP})) begin
         addCycle(0, rnd(), rnd(), rnd(), rnd(), outv(0,0,0,0,0,0,2'b00,0,0,0,0,1,0,0));
         return;
      end
      addCycle(0, rnd(), rnd(), rnd(), rnd(), '0);
      isMul = 1'b0;
`ifdef MULTICYCLE_MUL_EN
      isMul = (op == R_OP) && (f7 == 7'b0000001);
`endif
      case (op)
         R_OP: begin
            addCycle(0, rnd(), rnd(), rnd(), rnd(), outv(0,0,0,0,0,0,2'b10,0,0,0,isMul,0,0,0));
            if (isMul) begin
               for (int k = 0; k < mWait; k++) addCycle(0, rnd(), rnd(), 0, rnd(), '0);
               addCycle(0, rnd(), rnd(), 1, rnd(), '0);
            end
            addWb(0, abortWb);
         end
         I_OP: begin
            addCycle(0, rnd(), rnd(), rnd(), rnd(), outv(0,0,0,0,0,0,2'b11,1,0,0,0,0,0,0));
            addWb(0, abortWb);
         end
         LW_OP: begin
            addCycle(0, rnd(), rnd(), rnd(), rnd(), outv(0,0,0,0,0,0,2'b00,1,0,0,0,0,0,0));
            addMemPhase(0, dWait, ok);
            if (!ok) begin addHalt(); return; end
            addWb(1, abortWb);
         end
         SW_OP: begin
            addCycle(0, rnd(), rnd(), rnd(), rnd(), outv(0,0,0,0,0,0,2'b00,1,0,0,0,0,0,0));
            addMemPhase(0, dWait, ok);
            if (!ok) begin addHalt(); return; end
            retire();
         end
         default: begin
            addCycle(0, rnd(), rnd(), rnd(), zero, outv(zero,zero,0,0,0,0,2'b01,0,0,0,0,0,0,0));
            retire();
         end
      endcase
   endtask

   function automatic int randWait();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return 0;
      if (r < 9) return $urandom_range(1, TO - 1);
      return $urandom_range(TO, TO + 1);
   endfunction

   task automatic applyStimulus(input cycle_t c);
      rst_i       = c.rst;
      Op_i        = c.op;
      Funct7_i    = c.f7;
      Zero_i      = c.zero;
      IMemReady_i = c.iRdy;
      DMemReady_i = c.dRdy;
      MulDone_i   = c.mDone;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      logic [6:0] op;
      logic [6:0] f7;
      int         sel;
      int         idx;
      cycle_t     c;

      rst_i = 1'b1; Op_i = '0; Funct7_i = '0; Zero_i = 1'b0;
      IMemReady_i = 1'b0; DMemReady_i = 1'b0; MulDone_i = 1'b0;
      @(posedge clk_i); #1;

      addReset();
      addInstr(R_OP, 7'd0, 0, 0, 0, 0, 0);
      addInstr(LW_OP, 7'd0, 0, 3, 0, 0, 0);
      addInstr(BEQ_OP, 7'd0, 0, 0, 1, 0, 0);
      addInstr(BEQ_OP, 7'd0, 0, 0, 0, 0, 0);
      addInstr(7'b1111111, 7'd0, 0, 0, 0, 0, 0);
      addInstr(R_OP, 7'd0, TO - 1, 0, 0, 0, 0);
      addInstr(SW_OP, 7'd0, 0, TO - 1, 0, 0, 0);
      addInstr(R_OP, 7'b0000001, 0, 0, 0, 5, 0);
      addInstr(I_OP, 7'd0, 0, 0, 0, 0, 1);
      addInstr(R_OP, 7'd0, TO + 2, 0, 0, 0, 0);
      addInstr(LW_OP, 7'd0, 0, TO, 0, 0, 0);
      for (int n = 0; n < 18; n++)
         addInstr(BEQ_OP, 7'd0, 0, 0, rnd(), 0, 0);

      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         f7  = ($urandom_range(0, 2) == 0) ? 7'b0000001 : 7'($urandom);
         case (sel)
            0, 1:    op = R_OP;
            2:       op = I_OP;
            3, 4:    op = LW_OP;
            5, 6:    op = SW_OP;
            7, 8:    op = BEQ_OP;
            default: begin
               op = 7'($urandom);
               if (op inside {R_OP, I_OP, LW_OP, SW_OP, BEQ_OP}) op = 7'b1111111;
            end
         endcase
         addInstr(op, f7, randWait(), randWait(), rnd(), $urandom_range(0, 6),
                  $urandom_range(0, 19) == 0);
      end

      idx = 0;
      while (plan.size() > 0) begin
         c = plan.pop_front();
         applyStimulus(c);
         @(negedge clk_i);
         checkOutput($sformatf("cycle%0d outputs", idx),
                     32'({PCWrite_o, PCSrc_o, IRWrite_o, IMemReq_o, DMemReq_o, DMemWrite_o,
                          ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MulStart_o, Illegal_o,
                          BusErr_o, Halted_o}),
                     32'(c.expOut));
         checkOutput($sformatf("cycle%0d RetireCnt", idx), 32'(RetireCnt_o), 32'(c.expCnt));
         @(posedge clk_i); #1;
         idx++;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
